core_mc_control: RTL and testbench
==================================

CORE_MC_CONTROL -- requirements
Module: core_mc_control

Interface
REQ-001 The block SHALL have parameter TMO_CYCLES, default 16, giving the memory-wait timeout in cycles (used only under REQ-030).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 opcode_i  input  7  instr[6:0] from the instruction register.
REQ-005 mem_ack_i  input  1  shared-memory acknowledge; completes the pending access.
REQ-006 br_taken_i  input  1  branch-compare result from the ALU.
REQ-007 mem_req  output  1  shared-memory access request.
REQ-008 mem_we  output  1  memory write strobe, valid with mem_req.
REQ-009 mem_addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 ir_we  output  1  instruction register load strobe.
REQ-011 pc_we  output  1  PC update strobe.
REQ-012 pc_src  output  2  PC source: 00 = PC+4, 01 = PC+imm (branch/JAL), 10 = ALU result (JALR).
REQ-013 aluop  output  2  ALU class: 00 = load/store/jump add, 01 = branch, 10 = R-type, 11 = I-type.
REQ-014 alusrc  output  2  ALU operand B: 00 = rs2, 01 = imm, 10 = PC/link.
REQ-015 regwrite, memtoreg  outputs  1 each  register-file write enable and write-back select (1 = memory data).
REQ-016 illegal, fault  outputs  1 each  sticky error flags; state_o  output  3  current state.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-018 Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
REQ-019 FETCH SHALL drive mem_req=1, mem_addr_sel=0, mem_we=0, and stay until mem_ack_i=1; in the ack cycle ir_we=1 and next state is DECODE.
REQ-020 DECODE SHALL latch opcode_i into an internal register; a listed opcode goes to EXEC, any other goes to HALT and sets illegal.
REQ-021 In EXEC/MEM/WB, aluop and alusrc SHALL decode the latched opcode: R 10/00, I 11/01, LOAD 00/01, STORE 00/01, BRANCH 01/00, JAL 00/10, JALR 00/10; both outputs are 00 in other states.
REQ-022 EXEC transitions: LOAD/STORE to MEM; R/I/JAL/JALR to WB; BRANCH to FETCH with pc_we=1 and pc_src = br_taken_i ? 01 : 00.
REQ-023 MEM SHALL drive mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE, and hold them until mem_ack_i.
REQ-024 On the MEM ack: LOAD goes to WB; STORE goes to FETCH with pc_we=1, pc_src=00.
REQ-025 WB SHALL assert regwrite=1 for one cycle, memtoreg=1 only for LOAD, and pc_we=1 with pc_src 00 (R/I/LOAD), 01 (JAL) or 10 (JALR); next state is FETCH.
REQ-026 mem_ack_i while mem_req=0 SHALL be ignored; mem_req SHALL not drop before ack.
REQ-027 Strobes ir_we, pc_we and regwrite SHALL each be single-cycle and never asserted outside the states named above.
REQ-028 Latency with zero-wait ack SHALL be: BRANCH 3 cycles, R/I/JAL/JALR/STORE 4, LOAD 5; each wait cycle adds one.
REQ-029 HALT SHALL drive all strobes and mem_req to 0 and is left only by rst.

Configuration
REQ-030 With CORE_MC_TIMEOUT_EN defined, a wait counter SHALL clear on entry to FETCH/MEM and count each cycle without ack; after TMO_CYCLES such cycles the block SHALL enter HALT and set fault; an ack on that final cycle wins.
REQ-031 Without CORE_MC_TIMEOUT_EN, waits SHALL be unbounded, no counter logic SHALL be generated, and fault SHALL be tied to 0.

Reset
REQ-032 rst=1 at any clock edge SHALL force FETCH, clear the latched opcode, illegal, fault and the wait counter, and abort any pending access.
REQ-033 While rst=1, every output except state_o (=0) SHALL be 0; mem_req rises in the first cycle after rst deasserts.

Verification
REQ-034 R-type, ack same cycle as req -> states 0,1,2,4,0; regwrite=1 in cycle 4 only; aluop=10.
REQ-035 LOAD, MEM ack delayed 3 cycles -> mem_req held 4 cycles with mem_addr_sel=1, then WB with memtoreg=1; total 8 cycles.
REQ-036 BRANCH, br_taken_i=1 then 0 -> pc_src=01 then 00 in EXEC, no regwrite; 3 cycles each.
REQ-037 Opcode 1111111 -> HALT, illegal=1 sticky, no strobes until rst.
REQ-038 Macro on, TMO_CYCLES=16, ack withheld in FETCH -> HALT, fault=1 after 16 cycles; ack on cycle 16 -> DECODE, fault=0.
REQ-039 rst asserted mid-MEM on a STORE -> next cycle FETCH, mem_we=0, flags cleared.

Source files
------------

// File: rtl/core_mc_control.sv
// core_mc_control: multi-cycle RV32 control FSM (fetch/decode/exec/mem/wb) with sticky error flags.
// Optional memory-wait timeout enabled by defining CORE_MC_TIMEOUT_EN.
module core_mc_control #(
   parameter int TMO_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode_i,
   input  logic       mem_ack_i,
   input  logic       br_taken_i,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic [1:0] aluop,
   output logic [1:0] alusrc,
   output logic       regwrite,
   output logic       memtoreg,
   output logic       illegal,
   output logic       fault,
   output logic [2:0] state_o
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   state_t     state, state_d;
   logic [6:0] opc;
   logic       ill_q, ill_set, flt_set;
   logic       req, we, asel, irwe, pcwe, rw, m2r;
   logic [1:0] pcsrc, al, as;
   logic       legal, in_dp, is_ld, is_st, is_br, is_jal, is_jalr;
   assign legal = opcode_i == OP_R || opcode_i == OP_I || opcode_i == OP_LOAD ||
                  opcode_i == OP_STORE || opcode_i == OP_BRANCH ||
                  opcode_i == OP_JAL || opcode_i == OP_JALR;
   assign is_ld   = opc == OP_LOAD;
   assign is_st   = opc == OP_STORE;
   assign is_br   = opc == OP_BRANCH;
   assign is_jal  = opc == OP_JAL;
   assign is_jalr = opc == OP_JALR;
   assign in_dp   = state == EXEC || state == MEM || state == WB;
   assign al = !in_dp ? 2'b00 : opc == OP_R ? 2'b10 : opc == OP_I ? 2'b11 : is_br ? 2'b01 : 2'b00;
   assign as = !in_dp ? 2'b00 : (opc == OP_I || is_ld || is_st) ? 2'b01 :
               (is_jal || is_jalr) ? 2'b10 : 2'b00;
`ifdef CORE_MC_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYCLES + 1);
   logic [CW-1:0] wcnt, wcnt_d;
   logic          flt_q, waiting;
   assign waiting = state == FETCH || state == MEM;
`endif
   always_comb begin
      state_d = state;
      req     = 1'b0;
      we      = 1'b0;
      asel    = 1'b0;
      irwe    = 1'b0;
      pcwe    = 1'b0;
      pcsrc   = 2'b00;
      rw      = 1'b0;
      m2r     = 1'b0;
      ill_set = 1'b0;
      flt_set = 1'b0;
      case (state)
         FETCH: begin
            req = 1'b1;
            irwe = mem_ack_i;
            state_d = mem_ack_i ? DECODE : FETCH;
         end
         DECODE: begin
            ill_set = !legal;
            state_d = legal ? EXEC : HALT;
         end
         EXEC: begin
            pcwe = is_br;
            pcsrc = (is_br && br_taken_i) ? 2'b01 : 2'b00;
            state_d = is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
         end
         MEM: begin
            req = 1'b1;
            asel = 1'b1;
            we = is_st;
            pcwe = mem_ack_i && is_st;
            state_d = !mem_ack_i ? MEM : is_st ? FETCH : WB;
         end
         WB: begin
            rw = 1'b1;
            m2r = is_ld;
            pcwe = 1'b1;
            pcsrc = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
            state_d = FETCH;
         end
         HALT: state_d = HALT;
         default: state_d = FETCH;
      endcase
`ifdef CORE_MC_TIMEOUT_EN
      // An ack on the last allowed cycle takes priority over the timeout.
      if (waiting && !mem_ack_i && wcnt == CW'(TMO_CYCLES - 1)) begin
         state_d = HALT;
         flt_set = 1'b1;
      end
`endif
   end
`ifdef CORE_MC_TIMEOUT_EN
   assign wcnt_d = (state_d != state) ? '0 : (waiting && !mem_ack_i) ? wcnt + 1'b1 : wcnt;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         opc   <= '0;
         ill_q <= 1'b0;
`ifdef CORE_MC_TIMEOUT_EN
         wcnt  <= '0;
         flt_q <= 1'b0;
`endif
      end else begin
         state <= state_d;
         if (state == DECODE) opc <= opcode_i;
         ill_q <= ill_q | ill_set;
`ifdef CORE_MC_TIMEOUT_EN
         wcnt  <= wcnt_d;
         flt_q <= flt_q | flt_set;
`endif
      end
   end
   assign mem_req      = !rst && req;
   assign mem_we       = !rst && we;
   assign mem_addr_sel = !rst && asel;
   assign ir_we        = !rst && irwe;
   assign pc_we        = !rst && pcwe;
   assign regwrite     = !rst && rw;
   assign memtoreg     = !rst && m2r;
   assign illegal      = !rst && ill_q;
   assign pc_src       = rst ? 2'b00 : pcsrc;
   assign aluop        = rst ? 2'b00 : al;
   assign alusrc       = rst ? 2'b00 : as;
   assign state_o      = rst ? 3'd0 : state;
`ifdef CORE_MC_TIMEOUT_EN
   assign fault = !rst && flt_q;
`else
   // Fault can never be raised without the timeout; the term keeps TMO_CYCLES referenced.
   assign fault = flt_set & (TMO_CYCLES < 0);
`endif
endmodule

// File: tb/tb_core_mc_control.sv
// tb_core_mc_control: frame scoreboard for core_mc_control; each queued frame holds
// the inputs for one cycle and the expected output vector for that cycle.
module tb_core_mc_control;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;
   typedef struct packed {
      logic        rst;
      logic        ack;
      logic        br;
      logic [6:0]  op;
      logic [17:0] exp;
   } frame_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode_i = '0;
   logic       mem_ack_i = 1'b0;
   logic       br_taken_i = 1'b0;
   logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, regwrite, memtoreg, illegal, fault;
   logic [1:0] pc_src, aluop, alusrc;
   logic [2:0] state_o;
   logic [17:0] obs;
   frame_t fq[$];
   string  tq[$];
   int checks = 0;
   int errors = 0;
   core_mc_control #(.TMO_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .opcode_i(opcode_i), .mem_ack_i(mem_ack_i), .br_taken_i(br_taken_i),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .aluop(aluop), .alusrc(alusrc), .regwrite(regwrite),
      .memtoreg(memtoreg), .illegal(illegal), .fault(fault), .state_o(state_o)
   );
   always #5 clk = ~clk;
   assign obs = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, aluop, alusrc,
                 regwrite, memtoreg, illegal, fault};
   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d req/we/as/ir/pc=%b ps=%b al=%b as=%b rw/m2r/ill/flt=%b, expected st=%0d req/we/as/ir/pc=%b ps=%b al=%b as=%b rw/m2r/ill/flt=%b",
                  tag, got[17:15], got[14:10], got[9:8], got[7:6], got[5:4], got[3:0],
                  exp[17:15], exp[14:10], exp[9:8], exp[7:6], exp[5:4], exp[3:0]);
      end
   endtask
   function automatic logic [17:0] e(input int st, input logic req, input logic we,
                                     input logic asel, input logic irwe, input logic pcwe,
                                     input logic [1:0] ps, input logic [3:0] alu,
                                     input logic rw, input logic m2r, input logic ill,
                                     input logic flt);
      logic [2:0] s;
      s = st[2:0];
      return {s, req, we, asel, irwe, pcwe, ps, alu, rw, m2r, ill, flt};
   endfunction
   // {aluop, alusrc} expected in EXEC/MEM/WB for each opcode class.
   function automatic logic [3:0] alu_of(input logic [6:0] op);
      case (op)
         OP_R:      return 4'b1000;
         OP_I:      return 4'b1101;
         OP_LOAD:   return 4'b0001;
         OP_STORE:  return 4'b0001;
         OP_BRANCH: return 4'b0100;
         default:   return 4'b0010;
      endcase
   endfunction
   task automatic push(input logic r, input logic a, input logic b, input logic [6:0] op,
                       input logic [17:0] exp, input string tag);
      fq.push_back('{rst: r, ack: a, br: b, op: op, exp: exp});
      tq.push_back(tag);
   endtask
   task automatic plan_reset(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b0, OP_R, '0, "reset");
   endtask
   task automatic plan_fetch(input logic [6:0] op, input int fw);
      for (int i = 0; i < fw; i++) push(0, 0, 0, op, e(0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), "fetch_wait");
      push(0, 1, 0, op, e(0, 1, 0, 0, 1, 0, 2'b00, 4'h0, 0, 0, 0, 0), "fetch_ack");
      push(0, 1, 0, op, e(1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), "decode");
   endtask
   task automatic plan_instr(input logic [6:0] op, input int fw, input int mw, input logic br);
      logic [3:0] a;
      logic st, ld;
      logic [1:0] ps;
      a  = alu_of(op);
      st = op == OP_STORE;
      ld = op == OP_LOAD;
      plan_fetch(op, fw);
      if (op == OP_BRANCH) begin
         push(0, 0, br, op, e(2, 0, 0, 0, 0, 1, br ? 2'b01 : 2'b00, a, 0, 0, 0, 0), "exec_br");
         return;
      end
      push(0, 0, br, op, e(2, 0, 0, 0, 0, 0, 2'b00, a, 0, 0, 0, 0), "exec");
      if (st || ld) begin
         for (int i = 0; i < mw; i++) push(0, 0, 0, op, e(3, 1, st, 1, 0, 0, 2'b00, a, 0, 0, 0, 0), "mem_wait");
         push(0, 1, 0, op, e(3, 1, st, 1, 0, st, 2'b00, a, 0, 0, 0, 0), "mem_ack");
         if (st) return;
      end
      ps = op == OP_JAL ? 2'b01 : op == OP_JALR ? 2'b10 : 2'b00;
      push(0, 0, 0, op, e(4, 0, 0, 0, 0, 1, ps, a, 1, ld, 0, 0), "wb");
   endtask
   initial begin
      frame_t f;
      string  t;
      plan_reset(2);
      plan_instr(OP_R, 0, 0, 0);
      plan_instr(OP_I, 1, 0, 0);
      plan_instr(OP_LOAD, 0, 3, 0);
      plan_instr(OP_STORE, 0, 0, 0);
      plan_instr(OP_STORE, 2, 2, 0);
      plan_instr(OP_BRANCH, 0, 0, 1);
      plan_instr(OP_BRANCH, 0, 0, 0);
      plan_instr(OP_JAL, 0, 0, 1);
      plan_instr(OP_JALR, 2, 0, 0);
      plan_instr(OP_LOAD, 1, 0, 0);
      // Store interrupted by reset while waiting in MEM.
      plan_fetch(OP_STORE, 0);
      push(0, 0, 0, OP_STORE, e(2, 0, 0, 0, 0, 0, 2'b00, 4'b0001, 0, 0, 0, 0), "exec");
      push(0, 0, 0, OP_STORE, e(3, 1, 1, 1, 0, 0, 2'b00, 4'b0001, 0, 0, 0, 0), "mem_wait");
      push(1, 1, 0, OP_STORE, '0, "rst_mid_mem");
      plan_instr(OP_R, 1, 0, 0);
      // Illegal opcode: sticky HALT, acks ignored.
      plan_fetch(OP_BAD, 0);
      for (int i = 0; i < 4; i++) push(0, i[0], 1, OP_BAD, e(5, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 1, 0), "halt_illegal");
      plan_reset(1);
      plan_instr(OP_JALR, 0, 0, 0);
`ifdef CORE_MC_TIMEOUT_EN
      plan_reset(1);
      for (int i = 0; i < 16; i++) push(0, 0, 0, OP_R, e(0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0), "tmo_wait");
      for (int i = 0; i < 2; i++) push(0, 1, 0, OP_R, e(5, 0, 0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0, 1), "tmo_halt");
      plan_reset(1);
      plan_instr(OP_R, 15, 0, 0);
      plan_instr(OP_LOAD, 0, 15, 0);
`endif
      while (fq.size() > 0) begin
         f = fq.pop_front();
         t = tq.pop_front();
         @(posedge clk);
         #1;
         rst = f.rst;
         mem_ack_i = f.ack;
         br_taken_i = f.br;
         opcode_i = f.op;
         #3;
         check(t, obs, f.exp);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
